// File: rtl/kbd_event_ctrl.sv
// PS/2 keyboard event controller: drains ps2_kbd bytes, folds E0/F0 prefixes
// into key events, and queues them for the CPU behind a single read word.
`timescale 1ns/1ps
module kbd_event_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  kb_data,
    input  logic        kb_ready,
    input  logic        kb_overflow,
    output logic        kb_rdn,
    input  logic        cpu_rd,
    output logic [31:0] cpu_rdata,
    output logic        irq
);

    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned CODE_W = 8;
    localparam int unsigned EVT_W  = CODE_W + 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_POP    = 2'd1,
        S_SETTLE = 2'd2
    } state_e;

    typedef struct packed {
        logic              ext;
        logic              brk;
        logic [CODE_W-1:0] code;
    } kbd_evt_t;

    state_e            state_q, state_d;
    logic              kb_rdn_q;
    logic              ext_q, ext_d;
    logic              brk_q, brk_d;
    logic              ovf_q, ovf_d;
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              irq_q;
    kbd_evt_t          mem_q [DEPTH];

    kbd_evt_t          evt;
    kbd_evt_t          head;
    logic              push;
    logic              pop;
    logic              wr_en;
    logic              drop;
    logic              empty;
    logic              full;

    // Drain sequencer: strobe once, then give ps2_kbd a cycle to refresh kb_ready.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (kb_ready) state_d = S_POP;
            S_POP:    state_d = S_SETTLE;
            S_SETTLE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Prefix folding of the byte sampled on the strobe cycle.
    always_comb begin
        ext_d = ext_q;
        brk_d = brk_q;
        push  = 1'b0;
        evt   = '{ext: ext_q, brk: brk_q, code: kb_data};
        if (state_q == S_POP) begin
            unique case (kb_data)
                8'hE0: ext_d = 1'b1;
                8'hF0: brk_d = 1'b1;
                8'h00, 8'hFF: begin
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
                default: begin
                    push  = 1'b1;
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end
    end

    // Event FIFO bookkeeping; a pop on a full FIFO makes room for a same-edge push.
    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == CNT_W'(DEPTH));
        pop     = cpu_rd && !empty;
        wr_en   = push && (!full || pop);
        drop    = push && full && !pop;
        wptr_d  = wr_en ? wptr_q + PTR_W'(1) : wptr_q;
        rptr_d  = pop   ? rptr_q + PTR_W'(1) : rptr_q;
        count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
        ovf_d   = ovf_q;
        if (cpu_rd) ovf_d = 1'b0;
        if (drop || kb_overflow) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            kb_rdn_q <= 1'b1;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            ovf_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            kb_rdn_q <= (state_d != S_POP);
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            ovf_q    <= ovf_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            irq_q    <= (count_d != '0);
        end
    end

    // Storage needs no reset: entries are only visible while counted valid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= evt;
    end

    assign head      = mem_q[rptr_q];
    assign kb_rdn    = kb_rdn_q;
    assign irq       = irq_q;
    assign cpu_rdata = {!empty, ovf_q, 20'd0, empty ? EVT_W'(0) : EVT_W'(head)};

endmodule

// File: tb/tb_kbd_event_ctrl.sv
// Scoreboard bench for kbd_event_ctrl with a ps2_kbd byte-source model.
`timescale 1ns/1ps
module tb_kbd_event_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  kb_data;
    logic        kb_ready;
    logic        kb_overflow;
    logic        kb_rdn;
    logic        cpu_rd;
    logic [31:0] cpu_rdata;
    logic        irq;

    kbd_event_ctrl #(.DEPTH(8), .PTR_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .kb_data    (kb_data),
        .kb_ready   (kb_ready),
        .kb_overflow(kb_overflow),
        .kb_rdn     (kb_rdn),
        .cpu_rd     (cpu_rd),
        .cpu_rdata  (cpu_rdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] src[$];
    logic [9:0] exp_q[$];
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic       exp_ovf = 1'b0;

    bit pend_pop = 1'b0;
    int pulses = 0;
    int low_run = 0;
    int dbl_low = 0;
    int high_run = 1000;
    int gap_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%08h want=%08h", tag, got, want);
        end
    endtask

    task automatic upd_kb();
        kb_ready = (src.size() != 0);
        kb_data  = (src.size() != 0) ? src[0] : 8'h00;
    endtask

    // One cycle: advance to the falling edge, then model ps2_kbd's reaction.
    task automatic tick();
        @(negedge clk);
        if (rst) begin
            pend_pop = 1'b0;
            low_run  = 0;
        end else begin
            if (pend_pop) begin
                if (src.size() != 0) void'(src.pop_front());
                pend_pop = 1'b0;
            end
            if (!kb_rdn) begin
                pend_pop = 1'b1;
                pulses++;
                gap_q.push_back(high_run);
                high_run = 0;
                low_run++;
                if (low_run > 1) dbl_low++;
            end else begin
                low_run = 0;
                high_run++;
            end
        end
        upd_kb();
    endtask

    task automatic feed(input logic [7:0] b);
        src.push_back(b);
        upd_kb();
        case (b)
            8'hE0: m_ext = 1'b1;
            8'hF0: m_brk = 1'b1;
            8'h00, 8'hFF: begin m_ext = 1'b0; m_brk = 1'b0; end
            default: begin
                if (exp_q.size() < 8) exp_q.push_back({m_ext, m_brk, b});
                else exp_ovf = 1'b1;
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        endcase
    endtask

    function automatic logic [31:0] exp_word();
        if (exp_q.size() == 0) return {1'b0, exp_ovf, 30'd0};
        return {1'b1, exp_ovf, 20'd0, exp_q[0]};
    endfunction

    task automatic drain();
        int n = 0;
        while ((src.size() != 0 || pend_pop) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) chk("drain_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic wait_pop(input string tag);
        int n = 0;
        while (kb_rdn && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic cpu_read(input string tag);
        chk({tag, "_irq"}, 32'(irq), 32'(exp_q.size() != 0));
        chk(tag, cpu_rdata, exp_word());
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        exp_ovf = 1'b0;
    endtask

    initial begin
        int p0;
        int g0;
        int mg;
        rst = 1'b1;
        cpu_rd = 1'b0;
        kb_overflow = 1'b0;
        upd_kb();
        repeat (3) tick();
        chk("rst_rdn", 32'(kb_rdn), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // Single make code and the one-cycle strobe
        p0 = pulses;
        feed(8'h1C);
        wait_pop("t1_pop_to");
        tick();
        chk("t1_direct", cpu_rdata, 32'h8000001C);
        chk("t1_irq", 32'(irq), 32'd1);
        drain();
        chk("t1_pulses", 32'(pulses - p0), 32'd1);
        cpu_read("t1_rd");
        cpu_read("t1_empty");

        // Extended release folded from three back-to-back bytes
        p0 = pulses;
        g0 = gap_q.size();
        feed(8'hE0); feed(8'hF0); feed(8'h75);
        drain();
        chk("t2_pulses", 32'(pulses - p0), 32'd3);
        mg = 1000;
        for (int i = g0 + 1; i < gap_q.size(); i++) if (gap_q[i] < mg) mg = gap_q[i];
        chk("t2_gap_ge2", 32'(mg >= 2), 32'd1);
        chk("t2_word", cpu_rdata, 32'h80000375);
        cpu_read("t2_rd");
        cpu_read("t2_empty");

        // Break prefix must not leak into the next event
        feed(8'hF0); feed(8'h1C); feed(8'h1C);
        drain();
        chk("t3_first", cpu_rdata, 32'h8000011C);
        cpu_read("t3_rd0");
        cpu_read("t3_rd1");
        cpu_read("t3_empty");

        // Overflow on the ninth push
        for (int i = 0; i < 9; i++) feed(8'(8'h15 + i));
        drain();
        chk("t4_first_ovf", cpu_rdata, 32'hC0000015);
        for (int i = 0; i < 8; i++) cpu_read($sformatf("t4_rd%0d", i));
        cpu_read("t4_empty");

        // kb_overflow alone sets the sticky flag
        kb_overflow = 1'b1;
        tick();
        kb_overflow = 1'b0;
        exp_ovf = 1'b1;
        cpu_read("t5_ovf");
        cpu_read("t5_clr");

        // Full FIFO: push and pop on the same edge
        for (int i = 0; i < 8; i++) feed(8'(8'h30 + i));
        drain();
        chk("t6_full_irq", 32'(irq), 32'd1);
        void'(exp_q.pop_front());
        feed(8'h40);
        wait_pop("t6_pop_to");
        chk("t6_head", cpu_rdata, 32'h80000030);
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        drain();
        chk("t6_no_ovf", cpu_rdata, 32'h80000031);
        for (int i = 0; i < 8; i++) cpu_read($sformatf("t6_rd%0d", i));
        cpu_read("t6_empty");

        // Reset during the strobe cycle, with an E0 prefix pending
        feed(8'hE0);
        drain();
        src.push_back(8'hF0);
        upd_kb();
        wait_pop("t7_pop_to");
        #2 rst = 1'b1;
        #1 chk("t7_rdn_async", 32'(kb_rdn), 32'd1);
        src.delete();
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_ovf = 1'b0;
        upd_kb();
        tick();
        rst = 1'b0;
        tick();
        chk("t7_rdata", cpu_rdata, 32'd0);
        chk("t7_irq", 32'(irq), 32'd0);
        feed(8'h29);
        drain();
        chk("t7_word", cpu_rdata, 32'h80000029);
        cpu_read("t7_rd");
        cpu_read("t7_empty");

        chk("no_double_low", 32'(dbl_low), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kbd_event_ctrl.md
Name: kbd_event_ctrl

Overview:
- Sequences the PS/2 keyboard receiver (ps2_kbd) on the CPU's behalf.
- Drains raw scan-code bytes with the receiver's active-low read strobe.
- Folds E0 (extended) and F0 (break) prefixes into single key events.
- Buffers the events in a small FIFO that the CPU pops through one memory-mapped read word.
- Sits between u_ps2_kbd and the CPU keyboard MMIO port; replaces the direct kb_rdata/kb_ready/sig_rd_kb wiring.

Parameters:
- DEPTH, 8: event FIFO entries; power of two, ≥2.
- PTR_W, 3: log2(DEPTH).

Ports:
- clk  in  1  system clock; same clock that drives ps2_kbd.
- rst  in  1  reset; asynchronous, active-high.
- kb_data  in  8  byte at head of the ps2_kbd FIFO.
- kb_ready  in  1  ps2_kbd has at least one byte.
- kb_overflow  in  1  ps2_kbd internal overflow flag.
- kb_rdn  out  1  active-low pop strobe to ps2_kbd.
- cpu_rd  in  1  one-cycle pulse: CPU load of the keyboard register.
- cpu_rdata  out  32  event word, described under Behaviour.
- irq  out  1  high while the event FIFO is non-empty.

Behaviour:
- Reset values:
  - kb_rdn=1, irq=0, cpu_rdata=0.
  - FIFO empty, ext_pend=0, brk_pend=0, ovf sticky=0, FSM=IDLE.
- Reset asserted mid-operation forces all of the above immediately. An in-flight kb_rdn low returns high asynchronously.
- Drain FSM, states IDLE, POP, SETTLE:
  - IDLE: if kb_ready=1, go to POP.
  - POP: kb_rdn=0 for exactly this one cycle. kb_data is sampled and decoded on this cycle's clock edge. Next state is SETTLE.
  - SETTLE: kb_rdn=1 for one cycle, giving ps2_kbd time to update kb_ready. Next state is IDLE.
  - Throughput is at most one byte per 3 cycles. kb_rdn is never low two consecutive cycles.
- Decode of the sampled byte b:
  - b=0xE0: ext_pend<=1. No event.
  - b=0xF0: brk_pend<=1. No event.
  - b=0x00 or 0xFF (keyboard error codes): discarded; ext_pend and brk_pend cleared. No event.
  - Any other b: push event {ext_pend, brk_pend, b} (10 bits); then clear both pend flags.
  - Sequences: E0 F0 xx yields ext=1, brk=1. F0 E0 xx yields the same event.
- Event FIFO:
  - Circular buffer with PTR_W-bit read/write pointers plus an occupancy count 0..DEPTH; pointers wrap modulo DEPTH.
  - Push while full: event dropped, ovf<=1, contents unchanged.
  - cpu_rd while non-empty pops the head on that clock edge.
  - cpu_rd while empty: no pop and no pointer change.
  - Simultaneous push and pop: both take effect, count unchanged. This holds when full: the pop frees the slot and the push is accepted, with no ovf. It also holds when empty: the pop is ignored, the push is accepted, and the count becomes 1.
- ovf sticky:
  - Set by a dropped push, or by kb_overflow=1 on any cycle.
  - Cleared by cpu_rd on the same edge; a set on that same edge wins.
- cpu_rdata is combinational from current state, valid in the cycle cpu_rd is high:
  - [31] valid = FIFO non-empty.
  - [30] ovf.
  - [29:10] zero.
  - [9] extended of head.
  - [8] release of head.
  - [7:0] scan code of head.
  - When valid=0, bits [9:0] read 0.
- irq = (count≠0), registered off the count. It updates the cycle after the push or pop.

Test Plan:
- Reset, then kb_ready=1 with kb_data=0x1C: kb_rdn low exactly 1 cycle. Next cycle cpu_rdata=0x8000001C and irq=1. cpu_rd pulse gives a following read of 0x00000000 and irq=0.
- Bytes E0,F0,75 delivered back to back: exactly 3 kb_rdn pulses, each separated by ≥2 high cycles. One event 0x80000375; no intermediate events.
- Bytes F0,1C then 1C: two events popped in order, 0x8000011C then 0x8000001C. Pend flags do not leak into the second event.
- Push 9 make codes 0x15..0x1D with no CPU reads: the 9th is dropped. Eight pops return 0x15..0x1C. The first pop's word has bit30=1; the second pop's word has bit30=0.
- FIFO full, with the push decode and cpu_rd on the same edge: the head pops, the new event is accepted, count stays 8, ovf stays 0.
- Assert rst while in POP: kb_rdn goes high asynchronously. After release, FIFO empty, cpu_rdata=0, and the next byte 0x29 is decoded with no stale prefix, giving 0x80000029.
